// File: rtl/snn_layer1_pkg.sv
// Shared definitions for the layer-1 spiking network blocks.
package snn_layer1_pkg;

    localparam int DEFAULT_NEURON_NUM_IN_SET = 20;
    localparam int DEFAULT_BIT_WIDTH_ADDR    = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } enc_state_e;

endpackage

// File: rtl/spike_priority_encoder.sv
// Lowest-set-bit encoder: returns the index of the lowest set bit and a
// one-hot mask selecting it (all zero when the input vector is empty).
module spike_priority_encoder #(
    parameter int WIDTH      = 20,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [WIDTH-1:0]      vec,
    output logic [ADDR_WIDTH-1:0] index,
    output logic [WIDTH-1:0]      clear_mask,
    output logic                  found
);

    // Scan upward; the found flag freezes the result at the first hit.
    always_comb begin
        index      = '0;
        clear_mask = '0;
        found      = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i] && !found) begin
                index         = ADDR_WIDTH'(i);
                clear_mask    = '0;
                clear_mask[i] = 1'b1;
                found         = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/post_spike_encoder_layer1.sv
// Captures the layer-1 post-spike vector and streams the index of every set
// bit, lowest first, over a valid/ready handshake.
module post_spike_encoder_layer1
    import snn_layer1_pkg::*;
#(
    parameter int NEURON_NUM_IN_SET = DEFAULT_NEURON_NUM_IN_SET,
    parameter int BIT_WIDTH_ADDR    = DEFAULT_BIT_WIDTH_ADDR
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NEURON_NUM_IN_SET-1:0] post_spike_i,
    input  logic                         post_spike_valid_i,
    input  logic                         this_sample_done_i,
    output logic [BIT_WIDTH_ADDR-1:0]    event_addr_o,
    output logic                         event_valid_o,
    input  logic                         event_ready_i,
    output logic                         busy_o,
    output logic                         scan_done_o,
    output logic [BIT_WIDTH_ADDR:0]      spike_count_o,
    output logic                         overflow_o
);

    enc_state_e                   state_r, state_nxt_s;
    logic [NEURON_NUM_IN_SET-1:0] pending_r, pending_nxt_s;
    logic [BIT_WIDTH_ADDR:0]      spike_count_r, spike_count_nxt_s;
    logic                         scan_done_r, scan_done_nxt_s;
    logic                         overflow_r, overflow_nxt_s;

    logic [BIT_WIDTH_ADDR-1:0]    lowest_idx_s;
    logic [NEURON_NUM_IN_SET-1:0] clear_mask_s;
    logic                         lowest_found_s;
    logic [NEURON_NUM_IN_SET-1:0] remaining_s;
    logic [BIT_WIDTH_ADDR:0]      popcount_s;
    logic                         xfer_s;
    logic                         final_xfer_s;
    logic                         capture_s;
    logic                         drop_s;

    spike_priority_encoder #(
        .WIDTH      (NEURON_NUM_IN_SET),
        .ADDR_WIDTH (BIT_WIDTH_ADDR)
    ) u_prio_enc (
        .vec        (pending_r),
        .index      (lowest_idx_s),
        .clear_mask (clear_mask_s),
        .found      (lowest_found_s)
    );

    assign remaining_s  = pending_r & ~clear_mask_s;
    assign xfer_s       = (state_r == SCAN) && event_ready_i && lowest_found_s;
    assign final_xfer_s = xfer_s && (remaining_s == '0);
    // A new vector is only taken when nothing of the old one is left unsent.
    assign capture_s    = post_spike_valid_i && ((state_r == IDLE) || final_xfer_s);
    assign drop_s       = post_spike_valid_i && (state_r == SCAN) && !final_xfer_s;

    // Population count of the incoming vector.
    always_comb begin
        popcount_s = '0;
        for (int i = 0; i < NEURON_NUM_IN_SET; i++) begin
            popcount_s = popcount_s + (BIT_WIDTH_ADDR + 1)'(post_spike_i[i]);
        end
    end

    // Next-state and next-output logic; flush overrides everything else.
    always_comb begin
        state_nxt_s       = state_r;
        pending_nxt_s     = pending_r;
        spike_count_nxt_s = spike_count_r;
        scan_done_nxt_s   = 1'b0;
        overflow_nxt_s    = overflow_r;
        if (this_sample_done_i) begin
            state_nxt_s       = IDLE;
            pending_nxt_s     = '0;
            spike_count_nxt_s = '0;
            overflow_nxt_s    = 1'b0;
        end else begin
            if (capture_s) begin
                pending_nxt_s     = post_spike_i;
                spike_count_nxt_s = popcount_s;
                if (post_spike_i != '0) begin
                    state_nxt_s     = SCAN;
                    scan_done_nxt_s = final_xfer_s;
                end else begin
                    state_nxt_s     = IDLE;
                    scan_done_nxt_s = 1'b1;
                end
            end else if (xfer_s) begin
                pending_nxt_s = remaining_s;
                if (final_xfer_s) begin
                    state_nxt_s     = IDLE;
                    scan_done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = SCAN;
                end
            end else begin
                state_nxt_s = state_r;
            end
            if (drop_s) begin
                overflow_nxt_s = 1'b1;
            end else begin
                overflow_nxt_s = overflow_r;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            pending_r     <= '0;
            spike_count_r <= '0;
            scan_done_r   <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pending_r     <= pending_nxt_s;
            spike_count_r <= spike_count_nxt_s;
            scan_done_r   <= scan_done_nxt_s;
            overflow_r    <= overflow_nxt_s;
        end
    end

    assign event_addr_o  = lowest_idx_s;
    assign event_valid_o = (state_r == SCAN);
    assign busy_o        = (state_r == SCAN);
    assign scan_done_o   = scan_done_r;
    assign spike_count_o = spike_count_r;
    assign overflow_o    = overflow_r;

endmodule

// File: tb/tb_post_spike_encoder_layer1.sv
// Scoreboard bench: stimulus pushes cycle-stamped expected events and
// scan-done pulses; a negedge monitor pops and compares them.
module tb_post_spike_encoder_layer1;

    localparam int N = 20;
    localparam int A = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] post_spike_i = '0;
    logic         post_spike_valid_i = 1'b0;
    logic         this_sample_done_i = 1'b0;
    logic [A-1:0] event_addr_o;
    logic         event_valid_o;
    logic         event_ready_i = 1'b0;
    logic         busy_o;
    logic         scan_done_o;
    logic [A:0]   spike_count_o;
    logic         overflow_o;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t ev_q[$];
    exp_t done_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   k;

    post_spike_encoder_layer1 #(
        .NEURON_NUM_IN_SET (N),
        .BIT_WIDTH_ADDR    (A)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .post_spike_i       (post_spike_i),
        .post_spike_valid_i (post_spike_valid_i),
        .this_sample_done_i (this_sample_done_i),
        .event_addr_o       (event_addr_o),
        .event_valid_o      (event_valid_o),
        .event_ready_i      (event_ready_i),
        .busy_o             (busy_o),
        .scan_done_o        (scan_done_o),
        .spike_count_o      (spike_count_o),
        .overflow_o         (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input int a);
        exp_t e;
        e.cyc = c;
        e.val = a;
        ev_q.push_back(e);
    endtask

    task automatic push_done(input int c, input int cnt);
        exp_t e;
        e.cyc = c;
        e.val = cnt;
        done_q.push_back(e);
    endtask

    // Monitor: every transfer and every scan_done pulse must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (event_valid_o && event_ready_i) begin
                if (ev_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: got addr %0d, expected no event (cycle %0d)", event_addr_o, cyc);
                end else begin
                    e = ev_q.pop_front();
                    chk("event_addr", int'(event_addr_o), e.val);
                    chk("event_cycle", cyc, e.cyc);
                end
            end
            if (scan_done_o) begin
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_scan_done: got pulse, expected none (cycle %0d)", cyc);
                end else begin
                    e = done_q.pop_front();
                    chk("scan_done_cycle", cyc, e.cyc);
                    chk("scan_done_count", int'(spike_count_o), e.val);
                end
            end
        end
    end

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(event_valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(scan_done_o), 0);
        chk("rst_count", int'(spike_count_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        chk("rst_addr", int'(event_addr_o), 0);
        reset_n = 1'b1;
        tick();

        // 20'h00005, ready high: addr 0, addr 2, done
        k = cyc;
        post_spike_i = 20'h00005; post_spike_valid_i = 1'b1; event_ready_i = 1'b1;
        push_ev(k + 1, 0); push_ev(k + 2, 2); push_done(k + 3, 2);
        tick();
        post_spike_valid_i = 1'b0;
        chk("c5_count", int'(spike_count_o), 2);
        chk("c5_busy", int'(busy_o), 1);
        repeat (3) tick();
        chk("c5_idle", int'(busy_o), 0);

        // Zero vector: done next cycle, no events
        k = cyc;
        post_spike_i = 20'h00000; post_spike_valid_i = 1'b1;
        push_done(k + 1, 0);
        tick();
        post_spike_valid_i = 1'b0;
        chk("zero_valid", int'(event_valid_o), 0);
        chk("zero_count", int'(spike_count_o), 0);
        tick();

        // 20'h80001 with ready low for 3 cycles
        k = cyc;
        post_spike_i = 20'h80001; post_spike_valid_i = 1'b1; event_ready_i = 1'b0;
        push_ev(k + 4, 0); push_ev(k + 5, 19); push_done(k + 6, 2);
        tick();
        post_spike_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", int'(event_valid_o), 1);
            chk("stall_addr", int'(event_addr_o), 0);
            tick();
        end
        event_ready_i = 1'b1;
        repeat (3) tick();

        // Overflow, then flush mid-scan with a coincident capture
        k = cyc;
        chk("ovf_pre", int'(overflow_o), 0);
        post_spike_i = 20'h00007; post_spike_valid_i = 1'b1;
        push_ev(k + 1, 0); push_ev(k + 2, 1);
        tick();
        post_spike_i = 20'hFFFFF;
        tick();
        chk("ovf_set", int'(overflow_o), 1);
        chk("ovf_count", int'(spike_count_o), 3);
        this_sample_done_i = 1'b1;
        post_spike_i = 20'h00001;
        tick();
        this_sample_done_i = 1'b0; post_spike_valid_i = 1'b0;
        chk("flush_ovf", int'(overflow_o), 0);
        chk("flush_busy", int'(busy_o), 0);
        chk("flush_count", int'(spike_count_o), 0);
        chk("flush_valid", int'(event_valid_o), 0);
        repeat (2) tick();

        // Back-to-back capture on the final transfer
        k = cyc;
        post_spike_i = 20'h00010; post_spike_valid_i = 1'b1;
        push_ev(k + 1, 4);
        tick();
        post_spike_i = 20'h00003;
        push_done(k + 2, 2); push_ev(k + 2, 0); push_ev(k + 3, 1); push_done(k + 4, 2);
        tick();
        post_spike_valid_i = 1'b0;
        chk("b2b_busy", int'(busy_o), 1);
        repeat (3) tick();
        chk("b2b_idle", int'(busy_o), 0);

        // Reset mid-scan, then a normal capture
        post_spike_i = 20'h80001; post_spike_valid_i = 1'b1; event_ready_i = 1'b0;
        tick();
        post_spike_valid_i = 1'b0;
        tick();
        chk("mid_busy_pre", int'(busy_o), 1);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_valid", int'(event_valid_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_count", int'(spike_count_o), 0);
        chk("mid_rst_done", int'(scan_done_o), 0);
        chk("mid_rst_ovf", int'(overflow_o), 0);
        chk("mid_rst_addr", int'(event_addr_o), 0);
        tick();
        reset_n = 1'b1;
        tick();
        k = cyc;
        post_spike_i = 20'h00003; post_spike_valid_i = 1'b1; event_ready_i = 1'b1;
        push_ev(k + 1, 0); push_ev(k + 2, 1); push_done(k + 3, 2);
        tick();
        post_spike_valid_i = 1'b0;
        chk("post_rst_count", int'(spike_count_o), 2);

        // Drain with a bounded wait
        for (int i = 0; i < 20; i++) begin
            if (ev_q.size() != 0 || done_q.size() != 0) tick();
        end
        tick();
        chk("ev_q_empty", ev_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
